// File: rtl/shift_frame_ctrl_pkg.sv
// Shared types for the serial frame controller.
// State enum, state encoding width, counter width helper.
package shift_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Bits needed to hold values 0..n-1, never less than 1.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_frame_ctrl_if.sv
// Producer-side handshake plus serial output bundle.
// master: producer/consumer side, slave: shift_frame_ctrl.
interface shift_frame_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             abort;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_valid,
        output in_data,
        output abort,
        input  in_ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  abort,
        output in_ready,
        output sout,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_frame_sreg.sv
// WIDTH-bit parallel-load left-shift register, MSB out.
// Ports: clk, resetn (async clear), load_i, shift_i, data_i, msb_o.
module shift_frame_sreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] sreg_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
        end else if (shift_i) begin
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/shift_frame_ctrl.sv
// Serializes parallel words MSB first with done pulse and idle gap.
// Ports: clk, resetn, bus (slave). Optional SHIFT_CTRL_PARITY_EN.
module shift_frame_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                clk,
    input  logic                resetn,
    shift_frame_ctrl_if.slave   bus
);

    localparam int CW = ctr_width(WIDTH);
    localparam int GW = ctr_width(GAP + 1);
    localparam logic [CW-1:0] CNT_LD = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LD =
        (GAP > 0) ? GW'(GAP - 1) : '0;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [GW-1:0]   gap_q;
    logic            sout_q;
    logic            vld_q;
    logic            done_q;
`ifdef SHIFT_CTRL_PARITY_EN
    logic            par_q;
`endif

    logic accept;
    logic kill;
    logic last_bit;
    logic eof;
    logic sh_en;
    logic next_bit;

    assign bus.in_ready = (state_q == ST_IDLE) && !bus.abort && resetn;
    assign accept       = bus.in_valid && bus.in_ready;
    assign kill         = bus.abort && (state_q != ST_IDLE);
    assign last_bit     = (state_q == ST_SHIFT) && (cnt_q == '0);

`ifdef SHIFT_CTRL_PARITY_EN
    assign eof = !kill && (state_q == ST_PAR);
`else
    assign eof = !kill && last_bit;
`endif

    assign sh_en = (state_q == ST_SHIFT) && (cnt_q != '0) && !kill;

    // Loaded pre-shifted so the MSB is always the next bit to send;
    // the first bit goes straight from in_data into sout_q.
    shift_frame_sreg #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (accept),
        .shift_i (sh_en),
        .data_i  ({bus.in_data[WIDTH-2:0], 1'b0}),
        .msb_o   (next_bit)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (kill) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                gap_q   <= '0;
                sout_q  <= 1'b0;
                vld_q   <= 1'b0;
            end else if (eof) begin
                sout_q <= 1'b0;
                vld_q  <= 1'b0;
                done_q <= 1'b1;
                cnt_q  <= '0;
                if (GAP > 0) begin
                    state_q <= ST_GAP;
                    gap_q   <= GAP_LD;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            state_q <= ST_SHIFT;
                            cnt_q   <= CNT_LD;
                            sout_q  <= bus.in_data[WIDTH-1];
                            vld_q   <= 1'b1;
`ifdef SHIFT_CTRL_PARITY_EN
                            par_q   <= ^bus.in_data;
`endif
                        end
                    end
                    ST_SHIFT: begin
`ifdef SHIFT_CTRL_PARITY_EN
                        if (last_bit) begin
                            sout_q  <= par_q;
                            state_q <= ST_PAR;
                        end else begin
                            cnt_q  <= cnt_q - 1'b1;
                            sout_q <= next_bit;
                        end
`else
                        cnt_q  <= cnt_q - 1'b1;
                        sout_q <= next_bit;
`endif
                    end
                    ST_GAP: begin
                        if (gap_q == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.sout       = sout_q;
    assign bus.sout_valid = vld_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule
